// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC conversion sequencer: reference wait, auto-zero, fixed integrate and measured
// de-integrate, with overrange and saturation handling. Define AUTORANGE_EN to enable auto-ranging.
module dual_slope_ctrl #(
  parameter int CNT_W      = 16,
  parameter int AZ_CYCLES  = 16,
  parameter int INT_CYCLES = 1000,
  parameter int DEINT_MAX  = 2000,
  parameter int NRANGE     = 5,
  parameter int RANGE_INIT = 2,
  parameter int UP_TH      = 1900,
  parameter int DN_TH      = 150,
  parameter int ERR_HOLD   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic             data_valid_o,
  output logic [CNT_W-1:0] result_o,
  output logic             sign_o,
  output logic             overrange_o,
  output logic             error_o,
  output logic [1:0]       afe_sel_o,
  output logic [2:0]       range_sel_o,
  output logic             afe_reset_o,
  output logic             ref_sign_o
);

`ifdef AUTORANGE_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] AZ_LAST   = CNT_W'(AZ_CYCLES - 1);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DMAX      = CNT_W'(DEINT_MAX);
  localparam logic [CNT_W-1:0] DMAX_LAST = CNT_W'(DEINT_MAX - 1);
  localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_HOLD - 1);
  localparam logic [CNT_W-1:0] UP_LIM    = CNT_W'(UP_TH);
  localparam logic [CNT_W-1:0] DN_LIM    = CNT_W'(DN_TH);
  localparam logic [2:0]       RANGE_MAX = 3'(NRANGE - 1);
  localparam logic [2:0]       RANGE_RST = 3'(RANGE_INIT);

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_REF    = 3'd1,
    ST_AUTO_ZERO   = 3'd2,
    ST_INTEGRATE   = 3'd3,
    ST_DEINTEGRATE = 3'd4,
    ST_DONE        = 3'd5,
    ST_ERROR       = 3'd6
  } state_e;

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] res_r, res_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic             pol_nxt_s;
  logic             done_s, err_s, sat_s;
  logic [2:0]       range_nxt_s;

  function automatic logic [1:0] afe_sel_f(input state_e s);
    case (s)
      ST_AUTO_ZERO:   return 2'b01;
      ST_INTEGRATE:   return 2'b10;
      ST_DEINTEGRATE: return 2'b11;
      default:        return 2'b00;
    endcase
  endfunction

  function automatic logic afe_reset_f(input state_e s);
    case (s)
      ST_RESET, ST_WAIT_REF, ST_ERROR: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  assign sat_s = sat_hi_i | sat_lo_i;

  // Next-state, phase counter and de-integrate capture; reference loss outranks saturation
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    res_nxt_s   = res_r;
    ovr_nxt_s   = ovr_r;
    pol_nxt_s   = ref_sign_o;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_RESET: begin
        state_nxt_s = ST_WAIT_REF;
        cnt_nxt_s   = CNT_ZERO;
      end
      ST_WAIT_REF: begin
        if (ref_ok_i) begin
          state_nxt_s = ST_AUTO_ZERO;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_WAIT_REF;
        end
      end
      ST_AUTO_ZERO: begin
        if (!ref_ok_i) begin
          state_nxt_s = ST_WAIT_REF;
        end else if (cnt_r == AZ_LAST) begin
          state_nxt_s = ST_INTEGRATE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_INTEGRATE: begin
        if (!ref_ok_i) begin
          state_nxt_s = ST_WAIT_REF;
        end else if (sat_s) begin
          state_nxt_s = ST_ERROR;
          cnt_nxt_s   = CNT_ZERO;
          err_s       = 1'b1;
        end else if (cnt_r == INT_LAST) begin
          state_nxt_s = ST_DEINTEGRATE;
          cnt_nxt_s   = CNT_ZERO;
          pol_nxt_s   = comp_i;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DEINTEGRATE: begin
        if (!ref_ok_i) begin
          state_nxt_s = ST_WAIT_REF;
        end else if (sat_s) begin
          state_nxt_s = ST_ERROR;
          cnt_nxt_s   = CNT_ZERO;
          err_s       = 1'b1;
        end else if (comp_i != ref_sign_o) begin
          state_nxt_s = ST_DONE;
          res_nxt_s   = cnt_r;
          ovr_nxt_s   = 1'b0;
        end else if (cnt_r == DMAX_LAST) begin
          state_nxt_s = ST_DONE;
          res_nxt_s   = DMAX;
          ovr_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (!ref_ok_i) begin
          state_nxt_s = ST_WAIT_REF;
        end else begin
          state_nxt_s = ST_AUTO_ZERO;
          cnt_nxt_s   = CNT_ZERO;
          done_s      = 1'b1;
        end
      end
      ST_ERROR: begin
        if (cnt_r == ERR_LAST) begin
          state_nxt_s = ST_RESET;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_RESET;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Range update on a completed conversion or a saturation abort (constant without auto-ranging)
  always_comb begin
    range_nxt_s = range_sel_o;
    if (AR_EN && done_s) begin
      if ((ovr_r || (res_r > UP_LIM)) && (range_sel_o < RANGE_MAX)) begin
        range_nxt_s = range_sel_o + 3'd1;
      end else if ((res_r < DN_LIM) && (range_sel_o != 3'd0)) begin
        range_nxt_s = range_sel_o - 3'd1;
      end else begin
        range_nxt_s = range_sel_o;
      end
    end else if (AR_EN && err_s && (range_sel_o < RANGE_MAX)) begin
      range_nxt_s = range_sel_o + 3'd1;
    end else begin
      range_nxt_s = range_sel_o;
    end
  end

  // State, counter and capture registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_RESET;
      cnt_r   <= CNT_ZERO;
      res_r   <= CNT_ZERO;
      ovr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      res_r   <= res_nxt_s;
      ovr_r   <= ovr_nxt_s;
    end
  end

  // Registered outputs; AFE controls decode the next state so they line up with state_r
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_valid_o <= 1'b0;
      result_o     <= CNT_ZERO;
      sign_o       <= 1'b0;
      overrange_o  <= 1'b0;
      error_o      <= 1'b0;
      afe_sel_o    <= 2'b00;
      afe_reset_o  <= 1'b1;
      ref_sign_o   <= 1'b0;
      range_sel_o  <= RANGE_RST;
    end else begin
      data_valid_o <= done_s;
      error_o      <= err_s;
      afe_sel_o    <= afe_sel_f(state_nxt_s);
      afe_reset_o  <= afe_reset_f(state_nxt_s);
      ref_sign_o   <= pol_nxt_s;
      range_sel_o  <= range_nxt_s;
      if (done_s) begin
        result_o    <= res_r;
        sign_o      <= ~ref_sign_o;
        overrange_o <= ovr_r;
      end
    end
  end

endmodule

// File: doc/dual_slope_ctrl.md
# dual_slope_ctrl

Parametrised dual-slope ADC conversion controller for the voltmeter digital core. It sequences the analog front end through reference-wait, auto-zero, fixed-time integrate and measured de-integrate phases, and returns a signed magnitude count per conversion. It adds overrange and saturation handling plus optional auto-ranging, and sits between the AFE switch/comparator interface and the display/readout logic.

## Interface
- CNT_W, 16: width of the phase counter and result_o.
- AZ_CYCLES, 16: auto-zero phase length in clocks (≥1).
- INT_CYCLES, 1000: integrate phase length in clocks (≥2).
- DEINT_MAX, 2000: de-integrate timeout, < 2^CNT_W.
- NRANGE, 5: number of ranges (≤8).
- RANGE_INIT, 2: range after reset.
- UP_TH, 1900: range-up threshold on result.
- DN_TH, 150: range-down threshold on result.
- ERR_HOLD, 8: clocks spent in ERROR.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- comp_i  in  1  integrator comparator, 1 = integrator output positive; already synchronous to clk_i.
- sat_hi_i / sat_lo_i  in  1 each  integrator saturation flags.
- ref_ok_i  in  1  reference voltage valid.
- data_valid_o  out  1  one-cycle result strobe.
- result_o  out  CNT_W  de-integrate count.
- sign_o  out  1  input polarity, 1 = negative.
- overrange_o  out  1  result saturated at DEINT_MAX.
- error_o  out  1  one-cycle strobe on saturation abort.
- afe_sel_o  out  2  00 idle, 01 auto-zero, 10 integrate, 11 de-integrate.
- range_sel_o  out  3  active range.
- afe_reset_o  out  1  integrator reset switch.
- ref_sign_o  out  1  de-integrate reference polarity.

## Operation
- States: RESET, WAIT_REF, AUTO_ZERO, INTEGRATE, DEINTEGRATE, DONE, ERROR.
- RESET → WAIT_REF unconditionally. WAIT_REF holds until ref_ok_i=1, then → AUTO_ZERO.
- AFE outputs are decoded from state:
  - afe_reset_o=1 in RESET, WAIT_REF and ERROR.
  - afe_sel_o: 01 in AUTO_ZERO, 10 in INTEGRATE, 11 in DEINTEGRATE, otherwise 00.
- AUTO_ZERO lasts exactly AZ_CYCLES cycles; INTEGRATE lasts exactly INT_CYCLES cycles.
- On the last INTEGRATE cycle, latch pol = comp_i. ref_sign_o = pol, held until the next latch. sign_o = ~pol is registered in DONE.
- DEINTEGRATE:
  - The counter starts at 0 on the first cycle and increments each cycle that comp_i == pol.
  - On the first cycle with comp_i != pol, result = counter → DONE.
  - If the counter reaches DEINT_MAX: result = DEINT_MAX, overrange=1 → DONE.
- DONE, one cycle:
  - Register result_o, sign_o, overrange_o.
  - Pulse data_valid_o.
  - Apply the range update, then → AUTO_ZERO (free-running conversions).
- sat_hi_i or sat_lo_i high in INTEGRATE or DEINTEGRATE → ERROR:
  - Pulse error_o.
  - Range up if not at max (auto-range builds only).
  - ERROR lasts ERR_HOLD cycles → RESET.
  - No data_valid_o; result_o keeps its previous value.
- ref_ok_i=0 in AUTO_ZERO, INTEGRATE, DEINTEGRATE or DONE → WAIT_REF next cycle, conversion discarded. If it coincides with saturation, ref_ok_i has priority.
- Unused state encodings → RESET.

## Timing
- Reset values:
  - data_valid_o=0, result_o=0, sign_o=0, overrange_o=0, error_o=0.
  - afe_sel_o=00, afe_reset_o=1, ref_sign_o=0, range_sel_o=RANGE_INIT.
- data_valid_o is high in the cycle after DONE is entered. Outputs are registered, and valid with data_valid_o.
- For a zero-crossing count N, the conversion period is AZ_CYCLES + INT_CYCLES + N + 2 clocks (DONE → DONE).
- N=0 is legal: comp_i already != pol on the first DEINTEGRATE cycle.
- A range change appears on range_sel_o in the same cycle data_valid_o rises, before the next AUTO_ZERO.
- Asynchronous reset mid-conversion returns to RESET immediately; no strobe is emitted.

## Configuration
- AUTORANGE_EN defined:
  - In DONE: if overrange or result > UP_TH, and range < NRANGE−1, then range+1.
  - Else if result < DN_TH and range > 0, then range−1.
  - In ERROR: range+1 if range < NRANGE−1.
- AUTORANGE_EN undefined: range_sel_o is constant RANGE_INIT, and thresholds are ignored.

## Test plan
Bench parameters: AZ_CYCLES=4, INT_CYCLES=8, DEINT_MAX=20, UP_TH=18, DN_TH=3, RANGE_INIT=2, ERR_HOLD=8.

- Reset, ref_ok_i=0 for 10 clocks, then 1 → afe_reset_o=1 throughout the wait; afe_sel_o=01 for 4 clocks, then 10 for 8 clocks.
- comp_i=1 during integrate, flip to 0 after 10 de-integrate cycles → result_o=10, sign_o=0, ref_sign_o=1, data_valid_o pulses once, range_sel_o stays 2.
- comp_i never flips → result_o=20, overrange_o=1; with AUTORANGE_EN range_sel_o=3, without it range_sel_o=2.
- comp_i=0 during integrate, flip to 1 after 1 cycle → result_o=1, sign_o=1; with AUTORANGE_EN range_sel_o 2→1; repeat conversions → range floors at 0.
- sat_hi_i pulse on integrate cycle 5 → error_o pulses, no data_valid_o, afe_reset_o=1 for 8 clocks, then RESET→WAIT_REF→AUTO_ZERO.
- ref_ok_i drops mid-DEINTEGRATE → WAIT_REF next clock, afe_sel_o=00, no data_valid_o; result_o unchanged.
